// File: rtl/dds_sweep_pkg.sv
// dds_sweep_pkg: shared definitions for the DDS linear frequency-sweep sequencer.
//   - DEF_PHASE_W / DEF_DWELL_W : default phase-step and dwell-counter widths
//   - sweep_state_t             : sequencer state encoding
package dds_sweep_pkg;

    localparam int unsigned DEF_PHASE_W = 32;
    localparam int unsigned DEF_DWELL_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_STEP,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/dds_sweep_dwell_timer.sv
// dds_sweep_dwell_timer: loadable down-counter timing how long each phase step is held.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load the counter from i_dwell (a dwell of 0 loads 1)
//   i_dwell        : dwell length in clock cycles
//   i_en           : decrement enable (counter saturates at 0)
//   o_tc           : terminal count, high while the count equals 1
module dds_sweep_dwell_timer
    import dds_sweep_pkg::*;
#(
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_en,
    output logic               o_tc
);

    logic [DWELL_W-1:0] r_count;
    logic [DWELL_W-1:0] w_load_val;

    assign w_load_val = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= w_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign o_tc = (r_count == DWELL_W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency-sweep sequencer for one DDS channel (DDS clock domain).
// Steps the phase increment from start to stop by a fixed increment, holding each
// value for max(dwell,1)+1 cycles; single-shot or continuous (sawtooth) sweeps.
// Optional macro DDS_SWEEP_PINGPONG_EN adds i_pingpong for triangle sweeps.
// Ports:
//   i_clk, i_rst_n    : DDS clock, asynchronous active-low reset
//   i_start, i_abort  : one-cycle start / abort requests (abort wins)
//   i_repeat          : restart automatically at the end of a sweep
//   i_start_step, i_stop_step, i_increment, i_dwell : sweep configuration (latched at start)
//   i_pingpong        : (DDS_SWEEP_PINGPONG_EN only) reverse direction at each end
//   o_phase_step      : phase step to the DDS
//   o_dds_sync        : one-cycle pulse at each sweep (re)start, drives DDS reset
//   o_busy            : sweep in progress
//   o_done            : one-cycle pulse when a non-repeating sweep completes
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int unsigned PHASE_W = DEF_PHASE_W,
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_repeat,
    input  logic [PHASE_W-1:0] i_start_step,
    input  logic [PHASE_W-1:0] i_stop_step,
    input  logic [PHASE_W-1:0] i_increment,
    input  logic [DWELL_W-1:0] i_dwell,
`ifdef DDS_SWEEP_PINGPONG_EN
    input  logic               i_pingpong,
`endif
    output logic [PHASE_W-1:0] o_phase_step,
    output logic               o_dds_sync,
    output logic               o_busy,
    output logic               o_done
);

    sweep_state_t       r_state, w_state_nxt;
    logic [PHASE_W-1:0] r_start, r_stop, r_inc, r_phase;
    logic [PHASE_W-1:0] w_start_nxt, w_stop_nxt, w_inc_nxt, w_phase_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic               r_repeat, w_repeat_nxt;
    logic               r_down, w_down_nxt;
    logic               r_sync, w_sync_nxt;
    logic               r_busy, w_busy_nxt;
    logic               w_tmr_load, w_tmr_en, w_tmr_tc;
`ifdef DDS_SWEEP_PINGPONG_EN
    logic               r_pp, w_pp_nxt;
`endif

    // Next value one increment toward tgt, clamped to tgt on carry/borrow,
    // overshoot or a zero increment.
    function automatic logic [PHASE_W-1:0] f_next(input logic [PHASE_W-1:0] cur,
                                                  input logic [PHASE_W-1:0] inc,
                                                  input logic [PHASE_W-1:0] tgt,
                                                  input logic               dn);
        logic [PHASE_W:0] sum;
        logic [PHASE_W:0] diff;
        logic             over;
        sum  = {1'b0, cur} + {1'b0, inc};
        diff = {1'b0, cur} - {1'b0, inc};
        if (dn) over = diff[PHASE_W] || (diff[PHASE_W-1:0] < tgt);
        else    over = sum[PHASE_W]  || (sum[PHASE_W-1:0]  > tgt);
        if (over || (inc == '0)) return tgt;
        return dn ? diff[PHASE_W-1:0] : sum[PHASE_W-1:0];
    endfunction

    dds_sweep_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_tmr_load),
        .i_dwell (r_dwell),
        .i_en    (w_tmr_en),
        .o_tc    (w_tmr_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_nxt  = r_start;
        w_stop_nxt   = r_stop;
        w_inc_nxt    = r_inc;
        w_dwell_nxt  = r_dwell;
        w_repeat_nxt = r_repeat;
        w_down_nxt   = r_down;
        w_phase_nxt  = r_phase;
        w_sync_nxt   = 1'b0;
        w_busy_nxt   = r_busy;
        w_tmr_load   = 1'b0;
        w_tmr_en     = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
        w_pp_nxt     = r_pp;
`endif
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        w_start_nxt  = i_start_step;
                        w_stop_nxt   = i_stop_step;
                        w_inc_nxt    = i_increment;
                        w_dwell_nxt  = i_dwell;
                        w_repeat_nxt = i_repeat;
`ifdef DDS_SWEEP_PINGPONG_EN
                        w_pp_nxt     = i_pingpong;
`endif
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    w_phase_nxt = r_start;
                    w_sync_nxt  = 1'b1;
                    w_down_nxt  = (r_start > r_stop);
                    w_tmr_load  = 1'b1;
                    w_state_nxt = ST_DWELL;
                end
                ST_DWELL: begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_tc) w_state_nxt = ST_STEP;
                end
                ST_STEP: begin
                    if (r_phase == r_stop) begin
                        if (!r_repeat) begin
                            w_state_nxt = ST_DONE;
`ifdef DDS_SWEEP_PINGPONG_EN
                        end else if (r_pp) begin
                            // Turnaround: the old start becomes the new target.
                            w_start_nxt = r_stop;
                            w_stop_nxt  = r_start;
                            w_down_nxt  = ~r_down;
                            w_phase_nxt = f_next(r_phase, r_inc, r_start, ~r_down);
                            w_tmr_load  = 1'b1;
                            w_state_nxt = ST_DWELL;
`endif
                        end else begin
                            w_state_nxt = ST_LOAD;
                        end
                    end else begin
                        w_phase_nxt = f_next(r_phase, r_inc, r_stop, r_down);
                        w_tmr_load  = 1'b1;
                        w_state_nxt = ST_DWELL;
                    end
                end
                ST_DONE: begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start  <= '0;
            r_stop   <= '0;
            r_inc    <= '0;
            r_dwell  <= '0;
            r_repeat <= 1'b0;
            r_down   <= 1'b0;
            r_phase  <= '0;
            r_sync   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
            r_pp     <= 1'b0;
`endif
        end else begin
            r_start  <= w_start_nxt;
            r_stop   <= w_stop_nxt;
            r_inc    <= w_inc_nxt;
            r_dwell  <= w_dwell_nxt;
            r_repeat <= w_repeat_nxt;
            r_down   <= w_down_nxt;
            r_phase  <= w_phase_nxt;
            r_sync   <= w_sync_nxt;
            r_busy   <= w_busy_nxt;
`ifdef DDS_SWEEP_PINGPONG_EN
            r_pp     <= w_pp_nxt;
`endif
        end
    end

    assign o_phase_step = r_phase;
    assign o_dds_sync   = r_sync;
    assign o_busy       = r_busy;
    assign o_done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: scoreboard bench for dds_sweep_ctrl. Each sweep pushes its
// expected per-cycle outputs to a queue; a negedge monitor pops and compares.
// Build with DDS_SWEEP_PINGPONG_EN defined to also exercise the triangle sweep.
module tb_dds_sweep_ctrl;

    typedef struct {
        logic [31:0] ph;
        logic        sy;
        logic        bz;
        logic        dn;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_start, i_abort, i_repeat;
    logic [31:0] i_start_step, i_stop_step, i_increment;
    logic [23:0] i_dwell;
`ifdef DDS_SWEEP_PINGPONG_EN
    logic        i_pingpong;
`endif
    logic [31:0] o_phase_step;
    logic        o_dds_sync, o_busy, o_done;

    exp_t        q[$];
    exp_t        m_e;
    logic [31:0] m_last;
    int unsigned n_checks;
    int unsigned n_fail;
    string       cur_test;

    dds_sweep_ctrl #(
        .PHASE_W (32),
        .DWELL_W (24)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_repeat     (i_repeat),
        .i_start_step (i_start_step),
        .i_stop_step  (i_stop_step),
        .i_increment  (i_increment),
        .i_dwell      (i_dwell),
`ifdef DDS_SWEEP_PINGPONG_EN
        .i_pingpong   (i_pingpong),
`endif
        .o_phase_step (o_phase_step),
        .o_dds_sync   (o_dds_sync),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got=%0h expected=%0h at %0t", cur_test, tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk_eq("phase", 64'(o_phase_step), 64'(m_e.ph));
            chk_eq("sync",  64'(o_dds_sync),   64'(m_e.sy));
            chk_eq("busy",  64'(o_busy),       64'(m_e.bz));
            chk_eq("done",  64'(o_done),       64'(m_e.dn));
        end
    end

    task automatic push(input logic [31:0] ph, input logic sy, input logic bz, input logic dn);
        exp_t e;
        e.ph = ph; e.sy = sy; e.bz = bz; e.dn = dn;
        q.push_back(e);
        m_last = ph;
    endtask

    // One increment from c toward tgt; clamps on overshoot, wrap or zero increment.
    function automatic logic [31:0] mdl_next(input logic [31:0] c, input logic [31:0] inc,
                                             input logic [31:0] tgt, input bit dn);
        logic [63:0] n;
        if (inc == 0) return tgt;
        if (dn) begin
            if (inc > c) return tgt;
            n = {32'd0, c} - {32'd0, inc};
            if (n < {32'd0, tgt}) return tgt;
        end else begin
            n = {32'd0, c} + {32'd0, inc};
            if (n > {32'd0, tgt}) return tgt;
        end
        return n[31:0];
    endfunction

    // Expected per-cycle trace: LOAD cycle, then nvals held values (or until done).
    task automatic push_sweep(input logic [31:0] s, input logic [31:0] st, input logic [31:0] inc,
                              input logic [23:0] d, input bit rpt, input bit pp,
                              input int unsigned nvals);
        logic [31:0] cur, a, b, t;
        bit          dn, sy;
        int unsigned h;
        h   = (d == 0) ? 2 : int'(d) + 1;
        a   = s;
        b   = st;
        dn  = (s > st);
        cur = s;
        sy  = 1'b1;
        push(m_last, 1'b0, 1'b1, 1'b0);
        for (int unsigned k = 0; k < nvals; k++) begin
            for (int unsigned c = 0; c < h; c++) push(cur, sy && (c == 0), 1'b1, 1'b0);
            sy = 1'b0;
            if (cur == b) begin
                if (!rpt) begin
                    push(b, 1'b0, 1'b1, 1'b1);
                    push(b, 1'b0, 1'b0, 1'b0);
                    break;
                end else if (pp) begin
                    t = a; a = b; b = t;
                    dn = !dn;
                    cur = mdl_next(cur, inc, b, dn);
                end else begin
                    push(b, 1'b0, 1'b1, 1'b0);
                    cur = a;
                    sy  = 1'b1;
                end
            end else begin
                cur = mdl_next(cur, inc, b, dn);
            end
        end
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] st, input logic [31:0] inc,
                           input logic [23:0] d, input logic rpt, input logic pp);
        i_start_step = s;
        i_stop_step  = st;
        i_increment  = inc;
        i_dwell      = d;
        i_repeat     = rpt;
`ifdef DDS_SWEEP_PINGPONG_EN
        i_pingpong   = pp;
`else
        if (pp) $display("note: pingpong request ignored in this build");
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while (q.size() > 0 && n < 3000) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            chk_eq("drain timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic run_single(input string name, input logic [31:0] s, input logic [31:0] st,
                              input logic [31:0] inc, input logic [23:0] d);
        cur_test = name;
        set_cfg(s, st, inc, d, 1'b0, 1'b0);
        push_sweep(s, st, inc, d, 1'b0, 1'b0, 64);
        pulse_start();
        wait_drain();
    endtask

    task automatic abort_now(input int unsigned n_idle);
        wait_drain();
        i_abort = 1'b1;
        for (int unsigned k = 0; k < n_idle; k++) push(m_last, 1'b0, 1'b0, 1'b0);
        tick();
        i_abort = 1'b0;
        wait_drain();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_last   = '0;
        cur_test = "reset";
        rst_n    = 1'b0;
        i_start  = 1'b0;
        i_abort  = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0, 1'b0);
        #2;
        chk_eq("rst phase", 64'(o_phase_step), 64'd0);
        chk_eq("rst sync",  64'(o_dds_sync),   64'd0);
        chk_eq("rst busy",  64'(o_busy),       64'd0);
        chk_eq("rst done",  64'(o_done),       64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        push(32'd0, 1'b0, 1'b0, 1'b0);
        push(32'd0, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // Basic up sweep; mid-sweep config changes and a second start are ignored.
        cur_test = "up10";
        set_cfg(32'd100, 32'd130, 32'd10, 24'd3, 1'b0, 1'b0);
        push_sweep(32'd100, 32'd130, 32'd10, 24'd3, 1'b0, 1'b0, 64);
        pulse_start();
        repeat (5) tick();
        set_cfg($urandom, $urandom, $urandom, 24'($urandom_range(0, 9)), 1'b1, 1'b1);
        pulse_start();
        wait_drain();

        run_single("up20clamp", 32'd100, 32'd130, 32'd20, 24'd2);
        run_single("down",      32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'h20, 24'd0);
        run_single("downborrow", 32'h10, 32'h5, 32'h20, 24'd1);
        run_single("upcarry",   32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd2);
        run_single("inc0",      32'd10, 32'd20, 32'd0, 24'd1);
        run_single("equal",     32'd55, 32'd55, 32'd7, 24'd2);

        // Start and abort together from IDLE: nothing happens.
        cur_test = "start+abort";
        set_cfg(32'd1, 32'd3, 32'd1, 24'd1, 1'b0, 1'b0);
        for (int unsigned k = 0; k < 4; k++) push(m_last, 1'b0, 1'b0, 1'b0);
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        wait_drain();

        // Continuous sawtooth, aborted in the STEP cycle of the third value 6.
        cur_test = "repeat";
        set_cfg(32'd5, 32'd7, 32'd1, 24'd1, 1'b1, 1'b0);
        push_sweep(32'd5, 32'd7, 32'd1, 24'd1, 1'b1, 1'b0, 8);
        pulse_start();
        abort_now(3);

        // Asynchronous reset in the middle of a dwell.
        cur_test = "rst mid-dwell";
        set_cfg(32'd100, 32'd130, 32'd10, 24'd3, 1'b0, 1'b0);
        push_sweep(32'd100, 32'd130, 32'd10, 24'd3, 1'b0, 1'b0, 64);
        pulse_start();
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk_eq("phase", 64'(o_phase_step), 64'd0);
        chk_eq("sync",  64'(o_dds_sync),   64'd0);
        chk_eq("busy",  64'(o_busy),       64'd0);
        chk_eq("done",  64'(o_done),       64'd0);
        tick();
        rst_n = 1'b1;
        push(32'd0, 1'b0, 1'b0, 1'b0);
        push(32'd0, 1'b0, 1'b0, 1'b0);
        wait_drain();

        run_single("after rst", 32'd200, 32'd170, 32'd15, 24'd2);

`ifdef DDS_SWEEP_PINGPONG_EN
        cur_test = "pingpong";
        set_cfg(32'd10, 32'd12, 32'd1, 24'd1, 1'b1, 1'b1);
        push_sweep(32'd10, 32'd12, 32'd1, 24'd1, 1'b1, 1'b1, 9);
        pulse_start();
        abort_now(3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
